// File: rtl/atm_session_ctrl_if.sv
// -----------------------------------------------------------------------------
// atm_session_ctrl_if
// Purpose : Bundles the session controller's user strobes, datapath handshake
//           and status outputs into one connection.
// Signals : card, enter, cancel   - single-cycle user strobes
//           menu_option[1:0]      - menu selection
//           status_code[3:0]      - registered datapath result
//           current_state[15:0]   - one-hot controller state
//           ready                 - one-cycle request strobe to the datapath
//           busy                  - datapath check outstanding
//           session_active        - customer logged in
//           pin_tries_left[2:0]   - remaining PIN attempts
//           last_status[3:0]      - status captured by the most recent check
// Modports: master - the session controller
//           slave  - the user front panel / datapath side
// -----------------------------------------------------------------------------
interface atm_session_ctrl_if;
  logic        card;
  logic        enter;
  logic        cancel;
  logic [1:0]  menu_option;
  logic [3:0]  status_code;
  logic [15:0] current_state;
  logic        ready;
  logic        busy;
  logic        session_active;
  logic [2:0]  pin_tries_left;
  logic [3:0]  last_status;

  modport master (
    input  card, enter, cancel, menu_option, status_code,
    output current_state, ready, busy, session_active, pin_tries_left, last_status
  );

  modport slave (
    output card, enter, cancel, menu_option, status_code,
    input  current_state, ready, busy, session_active, pin_tries_left, last_status
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// atm_session_ctrl
// Purpose : Crypto ATM session sequencer. Walks a customer session from the
//           user strobes, issues one-cycle ready requests to the datapath,
//           branches on its registered status_code, and handles PIN lockout,
//           result-message hold and cancel.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - atm_session_ctrl_if.master (strobes, handshake, status)
// Params  : MAX_PIN_TRIES (1..7), MSG_CYCLES (>=1), TIMEOUT_CYCLES
// Macro   : ATM_TIMEOUT_EN - when defined, adds an inactivity counter that
//           returns a stale session to IDLE after TIMEOUT_CYCLES.
// All outputs are registered.
// -----------------------------------------------------------------------------
module atm_session_ctrl #(
  parameter int unsigned MAX_PIN_TRIES  = 3,
  parameter int unsigned MSG_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  atm_session_ctrl_if.master bus
);

  localparam int unsigned MSG_W = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES) : 1;

  localparam logic [3:0] ST_ACC_FOUND     = 4'd1;
  localparam logic [3:0] ST_PIN_CORRECT   = 4'd3;
  localparam logic [3:0] ST_PIN_INCORRECT = 4'd4;
  localparam logic [3:0] ST_AMT_VALID     = 4'd5;

  typedef enum logic [15:0] {
    S_IDLE         = 16'h0001,
    S_ACC_NUM      = 16'h0002,
    S_PIN_INPUT    = 16'h0004,
    S_MENU         = 16'h0008,
    S_SHOW_BAL     = 16'h0010,
    S_CONVERT      = 16'h0020,
    S_SEL_CONV_1   = 16'h0040,
    S_SEL_CONV_2   = 16'h0080,
    S_WITHDRAW     = 16'h0100,
    S_SEL_AMT_WDR  = 16'h0200,
    S_TRANSFER     = 16'h0400,
    S_SEL_CUR_TRF  = 16'h0800,
    S_SEL_AMT_TRF  = 16'h1000,
    S_ERROR        = 16'h2000,
    S_SUCCESS      = 16'h4000
  } state_t;

  // Reject out-of-range configurations at elaboration.
  if (MAX_PIN_TRIES < 1 || MAX_PIN_TRIES > 7 || MSG_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("atm_session_ctrl: parameter out of range");
  end

  state_t             r_state;
  logic               r_ready;
  logic               r_busy;
  logic               r_session;
  logic [2:0]         r_tries;
  logic [3:0]         r_last;
  logic [MSG_W-1:0]   r_msg_cnt;

  logic               w_cancel;
  logic               w_timeout;
  logic [3:0]         w_sc;

  assign w_sc     = bus.status_code;
  assign w_cancel = bus.cancel && (r_state != S_IDLE);

`ifdef ATM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;

  // Inactivity counter: cleared by any strobe or in IDLE, frozen during a check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_IDLE) || bus.card || bus.enter || bus.cancel) begin
      r_to_cnt <= '0;
    end else if (!r_busy && (r_to_cnt != TO_W'(TIMEOUT_CYCLES))) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) && (r_state != S_IDLE);
`else
  assign w_timeout = 1'b0;
`endif

  // Session sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_session <= 1'b0;
      r_tries   <= 3'(MAX_PIN_TRIES);
      r_last    <= 4'd0;
      r_msg_cnt <= '0;
    end else begin
      r_ready <= 1'b0;
      // Message hold counter runs only while in SUCCESS/ERROR; zero elsewhere
      // so it starts from zero on the entry edge.
      if ((r_state != S_SUCCESS) && (r_state != S_ERROR)) begin
        r_msg_cnt <= '0;
      end

      if (w_cancel || w_timeout) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_session <= 1'b0;
      end else if (r_busy) begin
        // First busy cycle: datapath is registering status; second: decide.
        if (!r_ready) begin
          r_busy <= 1'b0;
          r_last <= w_sc;
          case (r_state)
            S_ACC_NUM:
              r_state <= (w_sc == ST_ACC_FOUND) ? S_PIN_INPUT : S_ERROR;
            S_PIN_INPUT: begin
              if (w_sc == ST_PIN_CORRECT) begin
                r_state   <= S_MENU;
                r_session <= 1'b1;
              end else if (w_sc == ST_PIN_INCORRECT) begin
                if (r_tries <= 3'd1) begin
                  r_tries <= 3'd0;
                  r_state <= S_ERROR;
                end else begin
                  r_tries <= r_tries - 3'd1;
                end
              end else begin
                r_state <= S_ERROR;
              end
            end
            S_SEL_CONV_1:
              r_state <= (w_sc == ST_AMT_VALID) ? S_SEL_CONV_2 : S_ERROR;
            S_SEL_CONV_2:
              r_state <= S_SUCCESS;
            S_SEL_AMT_WDR, S_SEL_AMT_TRF:
              r_state <= (w_sc == ST_AMT_VALID) ? S_SUCCESS : S_ERROR;
            S_TRANSFER:
              r_state <= (w_sc == ST_ACC_FOUND) ? S_SEL_CUR_TRF : S_ERROR;
            default:
              r_state <= r_state;
          endcase
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.card) begin
              r_state <= S_ACC_NUM;
              r_tries <= 3'(MAX_PIN_TRIES);
            end
          end
          S_ACC_NUM, S_PIN_INPUT, S_SEL_CONV_1, S_SEL_CONV_2,
          S_SEL_AMT_WDR, S_SEL_AMT_TRF, S_TRANSFER: begin
            if (bus.enter) begin
              r_ready <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_MENU: begin
            if (bus.enter) begin
              case (bus.menu_option)
                2'b00:   r_state <= S_SHOW_BAL;
                2'b01:   r_state <= S_CONVERT;
                2'b10:   r_state <= S_WITHDRAW;
                default: r_state <= S_TRANSFER;
              endcase
            end
          end
          S_SHOW_BAL:    if (bus.enter) r_state <= S_MENU;
          S_CONVERT:     if (bus.enter) r_state <= S_SEL_CONV_1;
          S_WITHDRAW:    if (bus.enter) r_state <= S_SEL_AMT_WDR;
          S_SEL_CUR_TRF: if (bus.enter) r_state <= S_SEL_AMT_TRF;
          S_SUCCESS, S_ERROR: begin
            if (r_msg_cnt == MSG_W'(MSG_CYCLES - 1)) begin
              r_state <= r_session ? S_MENU : S_IDLE;
            end else begin
              r_msg_cnt <= r_msg_cnt + MSG_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.current_state  = r_state;
  assign bus.ready          = r_ready;
  assign bus.busy           = r_busy;
  assign bus.session_active = r_session;
  assign bus.pin_tries_left = r_tries;
  assign bus.last_status    = r_last;

endmodule
